cb_rr_xbar: RTL

CB_RR_XBAR -- requirements
Module: cb_rr_xbar

---
 rtl/cb_rr_xbar.sv | 110 +++++++++++
 1 files changed

// File: rtl/cb_rr_xbar.sv
// NPORT x NPORT flit crossbar with one round-robin arbiter per output.
// Grants are held per packet (LOCK=1) or per flit (LOCK=0); output flits are registered.

module cb_rr_xbar #(
    parameter int unsigned NPORT = 5,
    parameter int unsigned DATAW = 64,
    parameter int unsigned VCHW  = 2,
    parameter int unsigned PORTW = 3,
    parameter bit          LOCK  = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic [NPORT*DATAW-1:0] idata,
    input  logic [NPORT-1:0]       ivalid,
    input  logic [NPORT-1:0]       itail,
    input  logic [NPORT*VCHW-1:0]  ivch,
    input  logic [NPORT*PORTW-1:0] port,
    input  logic [NPORT-1:0]       req,
    output logic [NPORT*NPORT-1:0] grt,
    output logic [NPORT*DATAW-1:0] odata,
    output logic [NPORT-1:0]       ovalid,
    output logic [NPORT*VCHW-1:0]  ovch
);

    typedef enum logic {StIdle, StBusy} arb_state_e;

    arb_state_e                        state_q [NPORT];
    arb_state_e                        state_d [NPORT];
    logic [NPORT-1:0][PORTW-1:0]       owner_q, owner_d;
    logic [NPORT-1:0][PORTW-1:0]       rr_q, rr_d;
    logic [NPORT-1:0][DATAW-1:0]       odata_q, odata_d;
    logic [NPORT-1:0][VCHW-1:0]        ovch_q, ovch_d;
    logic [NPORT-1:0]                  ovalid_q, ovalid_d;

    always_comb begin
        int   idx;
        int   o;
        logic found;
        idx      = 0;
        o        = 0;
        found    = 1'b0;
        state_d  = state_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        odata_d  = odata_q;
        ovch_d   = ovch_q;
        ovalid_d = '0;
        for (int j = 0; j < NPORT; j++) begin
            found = 1'b0;
            if (state_q[j] == StIdle) begin
                // Scan from the pointer; out-of-range port codes never equal any j.
                for (int k = 0; k < NPORT; k++) begin
                    idx = (int'(rr_q[j]) + k) % NPORT;
                    if (!found && req[idx] && (port[idx*PORTW +: PORTW] == PORTW'(j))) begin
                        found      = 1'b1;
                        state_d[j] = StBusy;
                        owner_d[j] = PORTW'(idx);
                        rr_d[j]    = PORTW'((idx + 1) % NPORT);
                    end
                end
            end else begin
                o = int'(owner_q[j]);
                if (ivalid[o]) begin
                    odata_d[j]  = idata[o*DATAW +: DATAW];
                    ovch_d[j]   = ivch[o*VCHW +: VCHW];
                    ovalid_d[j] = 1'b1;
                    if (!LOCK || itail[o]) begin
                        state_d[j] = StIdle;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int j = 0; j < NPORT; j++) begin
                state_q[j] <= StIdle;
            end
            owner_q  <= '0;
            rr_q     <= '0;
            odata_q  <= '0;
            ovch_q   <= '0;
            ovalid_q <= '0;
        end else begin
            for (int j = 0; j < NPORT; j++) begin
                state_q[j] <= state_d[j];
            end
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            odata_q  <= odata_d;
            ovch_q   <= ovch_d;
            ovalid_q <= ovalid_d;
        end
    end

    always_comb begin
        grt = '0;
        for (int j = 0; j < NPORT; j++) begin
            if (state_q[j] == StBusy) begin
                grt[int'(owner_q[j])*NPORT + j] = 1'b1;
            end
        end
    end

    assign odata  = odata_q;
    assign ovch   = ovch_q;
    assign ovalid = ovalid_q;

endmodule
